// File: rtl/time_sync_phc_wr_arb.sv
// PHC sync-write arbiter: captures per-interface sync timestamps into pending
// slots and issues one PHC time-set write per grant, with ack timeout.
module time_sync_phc_wr_arb #(
  parameter int IF_COUNT    = 2,
  parameter int TS_WIDTH    = 96,
  parameter int NS_LSB      = 16,
  parameter int NS_WIDTH    = 30,
  parameter int S_LSB       = 48,
  parameter int S_WIDTH     = 48,
  parameter int ARB_MODE    = 0,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IF_COUNT-1:0]          sync_wr_en,
  input  logic [IF_COUNT*TS_WIDTH-1:0] sync_wr_ts,
  output logic                         time_sync_wr_en,
  output logic [NS_WIDTH-1:0]          time_sync_wr_ns,
  output logic [S_WIDTH-1:0]           time_sync_wr_s,
  input  logic                         time_sync_wr_ack,
  output logic [IF_COUNT-1:0]          sync_pending,
  output logic [IF_COUNT-1:0]          sync_overrun,
  output logic                         sync_timeout,
  output logic                         busy
);

  localparam int IDX_W = (IF_COUNT > 1) ? $clog2(IF_COUNT) : 1;
  localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  if (NS_LSB + NS_WIDTH > TS_WIDTH) begin : g_ns_range_err
    $error("ns field exceeds TS_WIDTH");
  end
  if (S_LSB + S_WIDTH > TS_WIDTH) begin : g_s_range_err
    $error("s field exceeds TS_WIDTH");
  end
  if (IF_COUNT < 1 || IF_COUNT > 16) begin : g_if_count_err
    $error("IF_COUNT must be 1..16");
  end

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [NS_WIDTH-1:0] slot_ns [IF_COUNT];
  logic [S_WIDTH-1:0]  slot_s  [IF_COUNT];
  logic [IF_COUNT-1:0] pending;
  logic [IDX_W-1:0]    last_grant;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W:0]      cand;
  logic                found;
  logic [CNT_W-1:0]    to_cnt, cnt_next;
  logic                grant;
  logic                to_fire;

  // Only the ns/s fields are consumed; the rest of each timestamp is don't-care.
  logic unused_ts;
  assign unused_ts = ^sync_wr_ts;

  assign sync_pending    = pending;
  assign time_sync_wr_en = (state == WAIT_ACK);
  assign busy            = (state == WAIT_ACK);

  // Winner selection: lowest index, or first pending after the last grant.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    if (ARB_MODE == 0) begin
      for (int i = IF_COUNT - 1; i >= 0; i--) begin
        if (pending[i]) winner = IDX_W'(i);
      end
    end else begin
      for (int k = 0; k < IF_COUNT; k++) begin
        cand = {1'b0, last_grant} + (IDX_W+1)'(k + 1);
        if (cand >= (IDX_W+1)'(IF_COUNT)) cand = cand - (IDX_W+1)'(IF_COUNT);
        if (!found && pending[cand[IDX_W-1:0]]) begin
          winner = cand[IDX_W-1:0];
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    to_fire    = 1'b0;
    cnt_next   = to_cnt;
    case (state)
      IDLE: begin
        if (|pending) begin
          grant      = 1'b1;
          cnt_next   = '0;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        cnt_next = to_cnt + CNT_W'(1);
        // Ack takes precedence over a timeout landing on the same edge.
        if (time_sync_wr_ack) begin
          state_next = IDLE;
        end else if (ACK_TIMEOUT != 0 && cnt_next == CNT_W'(ACK_TIMEOUT)) begin
          to_fire    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pending         <= '0;
      sync_overrun    <= '0;
      sync_timeout    <= 1'b0;
      last_grant      <= IDX_W'(IF_COUNT - 1);
      to_cnt          <= '0;
      time_sync_wr_ns <= '0;
      time_sync_wr_s  <= '0;
      // NOTE: the slot memory is reset so a stale timestamp can never be issued.
      for (int i = 0; i < IF_COUNT; i++) begin
        slot_ns[i] <= '0;
        slot_s[i]  <= '0;
      end
    end else begin
      state        <= state_next;
      to_cnt       <= cnt_next;
      sync_timeout <= to_fire;
      if (grant) begin
        time_sync_wr_ns <= slot_ns[winner];
        time_sync_wr_s  <= slot_s[winner];
        last_grant      <= winner;
      end
      for (int i = 0; i < IF_COUNT; i++) begin
        // A capture on the granting edge refills the slot after the old value is issued.
        if (sync_wr_en[i]) begin
          slot_ns[i] <= sync_wr_ts[i*TS_WIDTH + NS_LSB +: NS_WIDTH];
          slot_s[i]  <= sync_wr_ts[i*TS_WIDTH + S_LSB +: S_WIDTH];
          pending[i] <= 1'b1;
        end else if (grant && winner == IDX_W'(i)) begin
          pending[i] <= 1'b0;
        end
        sync_overrun[i] <= sync_wr_en[i] && pending[i] && !(grant && winner == IDX_W'(i));
      end
    end
  end

endmodule
